// File: rtl/reg_write_demux_if.sv
// Write-request / clear / writeback-strobe bundle of reg_write_demux.
// The master side issues writes and clears; the slave side holds the registers.
interface reg_write_demux_if #(
    parameter int DATA_W   = 18,
    parameter int SEL_W    = 4,
    parameter int NUM_DEST = 16
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [SEL_W-1:0]           wr_sel;
    logic [DATA_W-1:0]          wr_data;
    logic                       clr_req;
    logic                       clr_done;
    logic [NUM_DEST-1:0]        dest_we;
    logic [DATA_W-1:0]          dest_data;
    logic [NUM_DEST*DATA_W-1:0] regs_flat;

    modport master (
        output wr_valid, wr_sel, wr_data, clr_req,
        input  wr_ready, clr_done, dest_we, dest_data, regs_flat
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, clr_req,
        output wr_ready, clr_done, dest_we, dest_data, regs_flat
    );
endinterface

// File: rtl/reg_write_demux.sv
// Writeback demux: routes one value into NUM_DEST registers with a one-hot strobe,
// plus a sequenced bulk clear. Optional macro ZERO_REG0_EN hardwires reg[0] to zero.
module reg_write_demux #(
    parameter int DATA_W   = 18,
    parameter int SEL_W    = 4,
    parameter int NUM_DEST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_write_demux_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     cnt_q, cnt_d;

    logic                 pend_valid_q;
    logic [SEL_W-1:0]     pend_sel_q;
    logic [DATA_W-1:0]    pend_data_q;

    logic [DATA_W-1:0]    regs_q [NUM_DEST];

    logic [NUM_DEST-1:0]  dest_we_q, dest_we_d;
    logic [DATA_W-1:0]    dest_data_q, dest_data_d;
    logic                 clr_done_q, clr_done_d;

    logic                 wr_ready;
    logic                 accept;
    logic                 step_we;
    logic [SEL_W-1:0]     step_sel;
    logic [DATA_W-1:0]    step_data;
    logic [NUM_DEST*DATA_W-1:0] regs_flat;

    // A pending clear outranks a new write so the sweep starts on time.
    assign wr_ready = (state_q == IDLE) && !bus.clr_req;
    assign accept   = bus.wr_valid && wr_ready;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        step_we    = 1'b0;
        step_sel   = pend_sel_q;
        step_data  = pend_data_q;

        case (state_q)
            IDLE: begin
                // A write accepted last edge drains now, ahead of any sweep.
                step_we = pend_valid_q;
                if (bus.clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                step_we   = 1'b1;
                step_sel  = cnt_q;
                step_data = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == SEL_W'(NUM_DEST - 1)) begin
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ZERO_REG0_EN
        // reg[0] is constant zero: its writes and its sweep step are silent.
        if (step_sel == '0) begin
            step_we = 1'b0;
        end
`endif

        dest_we_d   = step_we ? (NUM_DEST'(1) << step_sel) : '0;
        dest_data_d = step_we ? step_data : dest_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_sel_q   <= '0;
            pend_data_q  <= '0;
            dest_we_q    <= '0;
            dest_data_q  <= '0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= accept;
            if (accept) begin
                pend_sel_q  <= bus.wr_sel;
                pend_data_q <= bus.wr_data;
            end
            dest_we_q    <= dest_we_d;
            dest_data_q  <= dest_data_d;
            clr_done_q   <= clr_done_d;
        end
    end

    // NOTE: the register array is deliberately reset: downstream reads must see
    // zero after reset, so this storage cannot map to a reset-less RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DEST; i++) begin
                regs_q[i] <= '0;
            end
        end else if (step_we) begin
            regs_q[step_sel] <= step_data;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.clr_done  = clr_done_q;
    assign bus.dest_we   = dest_we_q;
    assign bus.dest_data = dest_data_q;
    assign bus.regs_flat = regs_flat;

endmodule
